// File: rtl/heartbeat_pkg.sv
// heartbeat_pkg: shared states, widths and helpers for the heartbeat Manchester receiver
package heartbeat_pkg;
  typedef enum logic [1:0] {HUNT, FRAME, LOCKED} state_t;
  localparam int BYTE_BITS = 8;
  localparam int MIN_HALF_BIT_CYCLES = 4;
  localparam int MAX_HALF_BIT_CYCLES = 255;
  localparam int TIMER_W = $clog2(4 * MAX_HALF_BIT_CYCLES + 1);
  function automatic logic [7:0] next_count(input logic [7:0] c);
    return c + 8'd1;
  endfunction
endpackage

// File: rtl/heartbeat_rx_decoder.sv
// manchester_bit_decoder: synchronises the line, finds mid-bit edges and emits decoded bits
module manchester_bit_decoder
  import heartbeat_pkg::*;
#(
  parameter int HALF_BIT_CYCLES = 8,
  parameter bit FIRST_HALF_IS_BIT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic signal_in,
  output logic bit_valid,
  output logic bit_value,
  output logic timeout,
  output logic synced
);
  localparam int HB = HALF_BIT_CYCLES < MIN_HALF_BIT_CYCLES ? MIN_HALF_BIT_CYCLES :
                      HALF_BIT_CYCLES > MAX_HALF_BIT_CYCLES ? MAX_HALF_BIT_CYCLES : HALF_BIT_CYCLES;
  localparam logic [TIMER_W-1:0] MID_THR = TIMER_W'(3 * HB / 2);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(4 * HB);
  logic sync1, sync2, line_q, edge_q, fall_q, sync_q, mid_edge;
  logic [TIMER_W-1:0] timer;
  assign mid_edge = edge_q && timer >= MID_THR;
  assign timeout = sync_q && timer == TIMER_MAX;
  assign bit_valid = sync_q && mid_edge && !timeout;
  assign bit_value = FIRST_HALF_IS_BIT ? fall_q : !fall_q;
  assign synced = sync_q;
  // two-flop synchroniser followed by a registered edge/direction detector
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      line_q <= 1'b0;
      edge_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync1 <= signal_in;
      sync2 <= sync1;
      line_q <= sync2;
      edge_q <= sync2 ^ line_q;
      fall_q <= line_q & !sync2;
    end
  // interval timer: restarts on accepted edges, loses bit sync on timeout (timeout beats a coincident edge)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      timer <= '0;
      sync_q <= 1'b0;
    end else if (timeout) begin
      sync_q <= 1'b0;
    end else if (edge_q && (mid_edge || !sync_q)) begin
      timer <= TIMER_W'(1);
      sync_q <= sync_q || mid_edge;
    end else if (timer != TIMER_MAX) begin
      timer <= timer + 1'b1;
    end
endmodule

// File: rtl/heartbeat_rx.sv
// heartbeat_rx: heartbeat stream receiver with byte alignment and count checking; HEARTBEAT_RX_ERRCNT_EN adds err_count
module heartbeat_rx
  import heartbeat_pkg::*;
#(
  parameter int HALF_BIT_CYCLES = 8,
  parameter bit FIRST_HALF_IS_BIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal_in,
  output logic [7:0] count,
  output logic       count_valid,
  output logic       locked,
  output logic       error
`ifdef HEARTBEAT_RX_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);
  localparam logic [4:0] FRAME_BITS = 5'(2 * BYTE_BITS);
  localparam logic [4:0] LAST_BIT = 5'(BYTE_BITS - 1);
  state_t state, state_n;
  logic [14:0] hist, hist_n;
  logic [15:0] shifted;
  logic [4:0] bcnt, bcnt_n;
  logic [7:0] count_n;
  logic streak, streak_n, cv_n, err_n;
  logic bit_valid, bit_value, timeout, synced, frame_match, byte_match;
  manchester_bit_decoder #(
    .HALF_BIT_CYCLES(HALF_BIT_CYCLES),
    .FIRST_HALF_IS_BIT(FIRST_HALF_IS_BIT)
  ) u_dec (
    .clk(clk),
    .rst_n(rst_n),
    .signal_in(signal_in),
    .bit_valid(bit_valid),
    .bit_value(bit_value),
    .timeout(timeout),
    .synced(synced)
  );
  // the window includes the arriving bit, so only 15 bits of history are stored
  assign shifted = {hist, bit_value};
  assign frame_match = shifted[7:0] == next_count(shifted[15:8]);
  assign byte_match = shifted[7:0] == next_count(count);
  // framing FSM: next state, history, bit counter, mismatch streak and output pulses
  always_comb begin
    state_n = state;
    hist_n = hist;
    bcnt_n = bcnt;
    streak_n = streak;
    count_n = count;
    cv_n = 1'b0;
    err_n = 1'b0;
    if (timeout) begin
      state_n = HUNT;
      hist_n = '0;
      bcnt_n = '0;
      streak_n = 1'b0;
      err_n = state != HUNT;
    end else if (state == HUNT) begin
      if (synced) begin
        state_n = FRAME;
        hist_n = '0;
        bcnt_n = '0;
      end
    end else if (bit_valid) begin
      hist_n = shifted[14:0];
      if (state == FRAME) begin
        bcnt_n = bcnt == FRAME_BITS ? bcnt : bcnt + 5'd1;
        if (bcnt >= FRAME_BITS - 5'd1 && frame_match) begin
          state_n = LOCKED;
          count_n = shifted[7:0];
          cv_n = 1'b1;
          bcnt_n = '0;
          streak_n = 1'b0;
        end
      end else begin
        bcnt_n = bcnt == LAST_BIT ? 5'd0 : bcnt + 5'd1;
        if (bcnt == LAST_BIT) begin
          count_n = shifted[7:0];
          cv_n = byte_match;
          err_n = !byte_match;
          streak_n = !byte_match;
          if (!byte_match && streak) begin
            state_n = FRAME;
            hist_n = '0;
            streak_n = 1'b0;
          end
        end
      end
    end
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HUNT;
      hist <= '0;
      bcnt <= '0;
      streak <= 1'b0;
      count <= '0;
      count_valid <= 1'b0;
      error <= 1'b0;
      locked <= 1'b0;
    end else begin
      state <= state_n;
      hist <= hist_n;
      bcnt <= bcnt_n;
      streak <= streak_n;
      count <= count_n;
      count_valid <= cv_n;
      error <= err_n;
      locked <= state_n == LOCKED;
    end
`ifdef HEARTBEAT_RX_ERRCNT_EN
  // saturating tally of error pulses, cleared only by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_count <= '0;
    else if (err_n && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`endif
endmodule

// File: tb/tb_heartbeat_rx.sv
// tb_heartbeat_rx: directed bench driving a model heartbeat transmitter into heartbeat_rx
module tb_heartbeat_rx;
  logic clk = 1'b0;
  logic rst_n, signal_in;
  logic [7:0] count;
  logic count_valid, locked, error;
`ifdef HEARTBEAT_RX_ERRCNT_EN
  logic [15:0] err_count;
`endif
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int err_tot = 0;
  int both_tot = 0;
  logic [7:0] cv_val[$];
  int cv_cyc[$];
  logic cv_lock[$];
  int base, e0;

  heartbeat_rx #(.HALF_BIT_CYCLES(8), .FIRST_HALF_IS_BIT(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .signal_in(signal_in),
    .count(count),
    .count_valid(count_valid),
    .locked(locked),
    .error(error)
`ifdef HEARTBEAT_RX_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (count_valid) begin
      cv_val.push_back(count);
      cv_cyc.push_back(cyc);
      cv_lock.push_back(locked);
    end
    if (error) err_tot++;
    if (error && count_valid) both_tot++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int b, input logic [7:0] first, input int n);
    logic [7:0] e;
    check({tag, "_n"}, cv_val.size() - b, n);
    for (int k = 0; k < n; k++) begin
      e = first + 8'(k);
      check(tag, (b + k < cv_val.size()) ? {24'd0, cv_val[b + k]} : 'x, {24'd0, e});
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int hb, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      signal_in = b[i];
      repeat (hb) @(negedge clk);
      signal_in = ~b[i];
      repeat (hb) @(negedge clk);
    end
  endtask

  task automatic send_run(input logic [7:0] first, input int nbytes, input int hb);
    for (int k = 0; k < nbytes; k++) send_bits(first + 8'(k), hb, 8);
  endtask

  task automatic idle(input logic lvl);
    signal_in = lvl;
    repeat (60) @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic snap;
    base = cv_val.size();
    e0 = err_tot;
  endtask

  initial begin
    rst_n = 1'b0;
    signal_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_cv", count_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_error", error, 0);
`ifdef HEARTBEAT_RX_ERRCNT_EN
    check("rst_errcnt", err_count, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    idle(1'b1);
    snap();
    send_run(8'hFC, 6, 8);
    check_seq("wrap", base, 8'hFE, 4);
    check("wrap_err", err_tot - e0, 0);
    check("wrap_locked", locked, 1);
    do_reset();
    idle(1'b0);
    snap();
    send_run(8'h10, 7, 8);
    check_seq("lock", base, 8'h12, 5);
    check("lock_with_cv", cv_lock[base], 1);
    check("cv_spacing", cv_cyc[base + 1] - cv_cyc[base], 128);
    check("lock_err", err_tot - e0, 0);
    send_run(8'h17, 30, 8);
    check("run_err", err_tot - e0, 0);
    check("run_count", count, 8'h34);
    check("run_locked", locked, 1);
    snap();
    send_bits(8'h75, 8, 8);
    check("bad1_err", err_tot - e0, 1);
    check("bad1_locked", locked, 1);
    check("bad1_count", count, 8'h75);
    check("bad1_cv", cv_val.size() - base, 0);
    send_bits(8'h36, 8, 8);
    check("bad2_err", err_tot - e0, 2);
    check("bad2_locked", locked, 0);
    check("bad2_count", count, 8'h36);
    send_run(8'h37, 2, 8);
    check_seq("relock", base, 8'h38, 1);
    check("relock_locked", locked, 1);
    check("relock_err", err_tot - e0, 2);
    send_run(8'h39, 2, 8);
    snap();
    repeat (40) @(negedge clk);
    check("tmo_err", err_tot - e0, 1);
    check("tmo_locked", locked, 0);
    check("tmo_count", count, 8'h3A);
    check("tmo_cv", cv_val.size() - base, 0);
    send_run(8'h3B, 10, 8);
    check("resume_locked", locked, 1);
`ifdef HEARTBEAT_RX_ERRCNT_EN
    check("errcnt3", err_count, 3);
`endif
    send_bits(8'h45, 8, 4);
    check("pre_rst_count", count, 8'h44);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_cv", count_valid, 0);
    check("midrst_locked", locked, 0);
    check("midrst_error", error, 0);
`ifdef HEARTBEAT_RX_ERRCNT_EN
    check("midrst_errcnt", err_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle(1'b0);
    snap();
    send_run(8'h10, 6, 6);
    check_seq("rate6", base, 8'h12, 4);
    check("rate6_spacing", cv_cyc[base + 1] - cv_cyc[base], 96);
    check("rate6_err", err_tot - e0, 0);
    do_reset();
    idle(1'b0);
    snap();
    send_run(8'h10, 6, 10);
    check_seq("rate10", base, 8'h12, 4);
    check("rate10_spacing", cv_cyc[base + 1] - cv_cyc[base], 160);
    check("rate10_err", err_tot - e0, 0);
    check("cv_err_overlap", both_tot, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
